// File: rtl/uart_channel_arbiter_pkg.sv
// Shared types and constants for the UART channel arbiter: FSM state encodings
// and the framing byte width.
package uart_arb_pkg;

    localparam int MAX_PAYLOAD = 255;
    localparam int BYTE_W      = $clog2(MAX_PAYLOAD + 1);

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_HDR  = 2'd1,
        T_LEN  = 2'd2,
        T_DATA = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_HDR  = 2'd0,
        R_LEN  = 2'd1,
        R_DATA = 2'd2,
        R_DROP = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_channel_arbiter_if.sv
// Bundle of requester-side and uart_trans-side signals for the channel arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface uart_channel_arbiter_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]   tx_req;
    logic [8*NUM_CH-1:0] tx_len;
    logic [NUM_CH-1:0]   tx_grant;
    logic [8*NUM_CH-1:0] tx_data;
    logic [NUM_CH-1:0]   tx_valid;
    logic [NUM_CH-1:0]   tx_ready;

    logic [7:0]          rx_data;
    logic [NUM_CH-1:0]   rx_valid;
    logic                rx_last;
    logic [NUM_CH-1:0]   rx_ready;
    logic                rx_drop;

    logic                send_flag;
    logic [7:0]          send_data;
    logic                sendable;
    logic                recv_flag;
    logic [7:0]          recv_data;
    logic                receivable;

    modport master (
        input  tx_req, tx_len, tx_data, tx_valid, rx_ready,
               sendable, recv_data, receivable,
        output tx_grant, tx_ready, rx_data, rx_valid, rx_last, rx_drop,
               send_flag, send_data, recv_flag
    );

    modport slave (
        output tx_req, tx_len, tx_data, tx_valid, rx_ready,
               sendable, recv_data, receivable,
        input  tx_grant, tx_ready, rx_data, rx_valid, rx_last, rx_drop,
               send_flag, send_data, recv_flag
    );

endinterface

// File: rtl/uart_channel_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after i_last_grant
// (wrapping) wins; outputs are all zero when nobody requests.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_last_grant,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grant_idx
);

    logic            w_found;
    logic [CH_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        // Scan starts one past the last winner, so the last winner is checked last.
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_W'((int'(i_last_grant) + i) % NUM_CH);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_channel_arbiter.sv
// Shares one uart_trans byte link between NUM_CH requesters using
// [channel id][length][payload] framing in both directions.
module uart_channel_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_channel_arbiter_if.master bus
);

    localparam int    CH_W     = $clog2(NUM_CH);
    localparam byte_t NUM_CH_B = byte_t'(NUM_CH);

    tx_state_t         r_tx_state, w_tx_next;
    rx_state_t         r_rx_state, w_rx_next;
    logic [CH_W-1:0]   r_gnt, r_last_grant, r_ch, w_arb_idx;
    logic [NUM_CH-1:0] r_gnt_oh, w_arb_grant;
    byte_t             r_cnt, r_rcnt, w_req_len, w_tx_byte;
    logic              r_bad, w_hdr_bad, w_tx_push, w_rx_pop;

    rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr_arbiter (
        .i_req        (bus.tx_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_grant_idx  (w_arb_idx)
    );

    assign w_tx_push = bus.send_flag;
    assign w_rx_pop  = bus.recv_flag;
    assign w_hdr_bad = (bus.recv_data >= NUM_CH_B);

    // NOTE: every combinational output gets a default before the branches so no latch is inferred.
    always_comb begin
        w_req_len = '0;
        w_tx_byte = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_arb_idx == CH_W'(c)) w_req_len = bus.tx_len[c*8 +: 8];
            if (r_gnt == CH_W'(c))     w_tx_byte = bus.tx_data[c*8 +: 8];
        end
    end

    // ---------------- TX: arbitration and framing ----------------
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_tx_state <= T_IDLE;
        else      r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        unique case (r_tx_state)
            T_IDLE: if (|bus.tx_req) w_tx_next = T_HDR;
            T_HDR:  if (w_tx_push)   w_tx_next = T_LEN;
            T_LEN:  if (w_tx_push)   w_tx_next = (r_cnt == 8'd0) ? T_IDLE : T_DATA;
            T_DATA: if (w_tx_push && r_cnt == 8'd1) w_tx_next = T_IDLE;
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_grant  = '0;
        bus.tx_ready  = '0;
        bus.send_flag = 1'b0;
        bus.send_data = '0;
        unique case (r_tx_state)
            T_HDR: begin
                bus.tx_grant  = r_gnt_oh;
                bus.send_flag = bus.sendable;
                bus.send_data = byte_t'(r_gnt);
            end
            T_LEN: begin
                bus.tx_grant  = r_gnt_oh;
                bus.send_flag = bus.sendable;
                bus.send_data = r_cnt;
            end
            T_DATA: begin
                bus.tx_grant        = r_gnt_oh;
                bus.tx_ready[r_gnt] = bus.sendable;
                bus.send_flag       = bus.sendable & bus.tx_valid[r_gnt];
                bus.send_data       = w_tx_byte;
            end
            default: ;
        endcase
    end

    // last_grant resets to the top channel so channel 0 wins the first contest.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_gnt        <= '0;
            r_gnt_oh     <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_cnt        <= '0;
        end else if (r_tx_state == T_IDLE && |bus.tx_req) begin
            r_gnt        <= w_arb_idx;
            r_gnt_oh     <= w_arb_grant;
            r_last_grant <= w_arb_idx;
            r_cnt        <= w_req_len;
        end else if (r_tx_state == T_DATA && w_tx_push) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // ---------------- RX: parsing and routing ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_rx_state <= R_HDR;
        else      r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            R_HDR: if (w_rx_pop) w_rx_next = R_LEN;
            R_LEN: if (w_rx_pop) begin
                if (bus.recv_data == 8'd0) w_rx_next = R_HDR;
                else                       w_rx_next = r_bad ? R_DROP : R_DATA;
            end
            R_DATA, R_DROP: if (w_rx_pop && r_rcnt == 8'd1) w_rx_next = R_HDR;
            default: w_rx_next = R_HDR;
        endcase
    end

    always_comb begin
        bus.recv_flag = 1'b0;
        bus.rx_valid  = '0;
        bus.rx_data   = '0;
        bus.rx_last   = 1'b0;
        bus.rx_drop   = 1'b0;
        unique case (r_rx_state)
            R_HDR: begin
                bus.recv_flag = bus.receivable;
                bus.rx_drop   = bus.receivable & w_hdr_bad;
            end
            R_LEN, R_DROP: bus.recv_flag = bus.receivable;
            R_DATA: begin
                bus.rx_valid[r_ch] = bus.receivable;
                bus.rx_data        = bus.recv_data;
                bus.rx_last        = (r_rcnt == 8'd1);
                bus.recv_flag      = bus.receivable & bus.rx_ready[r_ch];
            end
            default: ;
        endcase
        // R_HDR pops on receivable alone, so gate it while reset is held.
        if (!RST) begin
            bus.recv_flag = 1'b0;
            bus.rx_drop   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ch   <= '0;
            r_bad  <= 1'b0;
            r_rcnt <= '0;
        end else if (w_rx_pop) begin
            unique case (r_rx_state)
                R_HDR: begin
                    r_ch  <= bus.recv_data[CH_W-1:0];
                    r_bad <= w_hdr_bad;
                end
                R_LEN:          r_rcnt <= bus.recv_data;
                R_DATA, R_DROP: r_rcnt <= r_rcnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_channel_arbiter.sv
// Directed bench for uart_channel_arbiter (NUM_CH = 2): TX framing, arbitration,
// backpressure, RX routing, bad-id drop and mid-packet reset.
module tb_uart_channel_arbiter;

    logic clk;
    logic rst_n;

    uart_channel_arbiter_if #(.NUM_CH(2)) bus ();

    uart_channel_arbiter #(.NUM_CH(2)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the UART RX FIFO feeding the arbiter.
    logic [7:0] q_mem [16];
    int         q_len    = 0;
    int         q_head   = 0;
    logic       pend_pop = 1'b0;
    int         drop_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (pend_pop) q_head++;
    endtask

    task automatic settle();
        bus.receivable = (q_head < q_len);
        bus.recv_data  = (q_head < q_len) ? q_mem[q_head] : 8'h00;
        #1;
        pend_pop = bus.recv_flag;
        if (bus.rx_drop) drop_cnt++;
    endtask

    logic [7:0] exp_stream [5];
    logic [7:0] pay [3];
    int         k;
    int         cyc;
    int         exp_ch;

    initial begin
        bus.tx_req   = '0;
        bus.tx_len   = '0;
        bus.tx_data  = '0;
        bus.tx_valid = '0;
        bus.rx_ready = '0;
        bus.sendable = 1'b1;
        bus.recv_data  = 8'h00;
        bus.receivable = 1'b0;
        rst_n = 1'b1;

        // Reset with a bad header waiting: nothing may pop or pulse.
        q_mem[0] = 8'h07; q_len = 1; q_head = 0;
        #1 rst_n = 1'b0;
        tick(); settle();
        check("rst_grant",     32'(bus.tx_grant),  0);
        check("rst_send_flag", 32'(bus.send_flag), 0);
        check("rst_send_data", 32'(bus.send_data), 0);
        check("rst_recv_flag", 32'(bus.recv_flag), 0);
        check("rst_rx_drop",   32'(bus.rx_drop),   0);
        check("rst_rx_valid",  32'(bus.rx_valid),  0);
        q_len = 0; q_head = 0;
        tick(); rst_n = 1'b1; settle();

        // Single packet, ch1, len 3.
        pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'hFF;
        exp_stream[0] = 8'h01; exp_stream[1] = 8'h03;
        exp_stream[2] = 8'hA5; exp_stream[3] = 8'h5A; exp_stream[4] = 8'hFF;
        tick();
        bus.tx_req = 2'b10; bus.tx_len[15:8] = 8'd3; bus.tx_valid = 2'b10;
        settle();
        check("t1_idle_grant", 32'(bus.tx_grant), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.tx_data[15:8] = (i >= 2) ? pay[i-2] : 8'h00;
            settle();
            check("t1_flag",  32'(bus.send_flag), 1);
            check("t1_data",  32'(bus.send_data), 32'(exp_stream[i]));
            check("t1_grant", 32'(bus.tx_grant),  2);
            if (i >= 2) check("t1_ready", 32'(bus.tx_ready), 2);
        end
        tick(); bus.tx_req = '0; settle();
        check("t1_end_flag",  32'(bus.send_flag), 0);
        check("t1_end_grant", 32'(bus.tx_grant),  0);

        // Contention: both channels, len 1, three packets -> 0,1,0.
        tick();
        bus.tx_req = 2'b11; bus.tx_len = {8'd1, 8'd1};
        bus.tx_valid = 2'b11; bus.tx_data = {8'h21, 8'h10};
        settle();
        check("t2_idle_grant", 32'(bus.tx_grant), 0);
        for (int p = 0; p < 3; p++) begin
            exp_ch = (p == 1) ? 1 : 0;
            tick(); settle();
            check("t2_hdr_grant", 32'(bus.tx_grant),  32'(1 << exp_ch));
            check("t2_hdr_data",  32'(bus.send_data), 32'(exp_ch));
            tick(); settle();
            check("t2_len_data",  32'(bus.send_data), 1);
            tick(); settle();
            check("t2_pay_data",  32'(bus.send_data), (exp_ch == 1) ? 32'h21 : 32'h10);
            check("t2_pay_flag",  32'(bus.send_flag), 1);
            tick();
            if (p == 2) bus.tx_req = '0;
            settle();
            check("t2_gap_grant", 32'(bus.tx_grant),  0);
            check("t2_gap_flag",  32'(bus.send_flag), 0);
        end

        // TX backpressure: sendable toggles, ch0 len 2.
        exp_stream[0] = 8'h00; exp_stream[1] = 8'h02;
        exp_stream[2] = 8'h33; exp_stream[3] = 8'h44;
        tick();
        bus.tx_req = 2'b01; bus.tx_len = {8'd0, 8'd2}; bus.tx_valid = 2'b01;
        settle();
        k = 0; cyc = 0;
        while (k < 4 && cyc < 20) begin
            tick();
            bus.sendable = cyc[0];
            bus.tx_data[7:0] = (k >= 2) ? exp_stream[k] : 8'h00;
            settle();
            check("t3_grant", 32'(bus.tx_grant),  1);
            check("t3_flag",  32'(bus.send_flag), 32'(bus.sendable));
            if (bus.sendable) begin
                check("t3_data", 32'(bus.send_data), 32'(exp_stream[k]));
                k++;
            end
            cyc++;
        end
        check("t3_bytes_pushed", 32'(k), 4);
        tick(); bus.tx_req = '0; bus.sendable = 1'b1; settle();
        check("t3_end_grant", 32'(bus.tx_grant), 0);

        // RX routing with ch0 stalled for 4 cycles.
        q_mem[0] = 8'h00; q_mem[1] = 8'h02; q_mem[2] = 8'h11; q_mem[3] = 8'h22;
        q_len = 4; q_head = 0; bus.rx_ready = 2'b00;
        tick(); settle();
        check("t4_hdr_pop", 32'(bus.recv_flag), 1);
        check("t4_hdr_valid", 32'(bus.rx_valid), 0);
        tick(); settle();
        check("t4_len_pop", 32'(bus.recv_flag), 1);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check("t4_stall_valid", 32'(bus.rx_valid),  1);
            check("t4_stall_data",  32'(bus.rx_data),   32'h11);
            check("t4_stall_pop",   32'(bus.recv_flag), 0);
            check("t4_stall_last",  32'(bus.rx_last),   0);
        end
        tick(); bus.rx_ready = 2'b01; settle();
        check("t4_b0_pop",  32'(bus.recv_flag), 1);
        check("t4_b0_data", 32'(bus.rx_data),   32'h11);
        tick(); settle();
        check("t4_b1_data", 32'(bus.rx_data),  32'h22);
        check("t4_b1_last", 32'(bus.rx_last),  1);
        check("t4_b1_valid", 32'(bus.rx_valid), 1);
        tick(); settle();
        check("t4_end_valid", 32'(bus.rx_valid), 0);
        check("t4_consumed",  32'(q_head),       4);

        // Bad id packet dropped, then empty packet for ch1.
        q_mem[0] = 8'h07; q_mem[1] = 8'h02; q_mem[2] = 8'hAA;
        q_mem[3] = 8'hBB; q_mem[4] = 8'h01; q_mem[5] = 8'h00;
        q_len = 6; q_head = 0; bus.rx_ready = 2'b00; drop_cnt = 0;
        tick(); settle();
        check("t5_drop_pulse", 32'(bus.rx_drop), 1);
        tick(); settle();
        check("t5_len_drop",   32'(bus.rx_drop),   0);
        check("t5_len_pop",    32'(bus.recv_flag), 1);
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            check("t5_drop_valid", 32'(bus.rx_valid),  0);
            check("t5_drop_pop",   32'(bus.recv_flag), 1);
        end
        tick(); settle();
        check("t5_hdr1_pop",  32'(bus.recv_flag), 1);
        check("t5_hdr1_drop", 32'(bus.rx_drop),   0);
        tick(); settle();
        check("t5_len1_pop",  32'(bus.recv_flag), 1);
        tick(); settle();
        check("t5_end_valid", 32'(bus.rx_valid), 0);
        check("t5_consumed",  32'(q_head),       6);
        check("t5_drop_count", 32'(drop_cnt),    1);

        // Reset mid-packet on both directions.
        q_mem[0] = 8'h00; q_mem[1] = 8'h03; q_mem[2] = 8'h11;
        q_mem[3] = 8'h22; q_mem[4] = 8'h33;
        q_len = 5; q_head = 0; bus.rx_ready = 2'b01;
        tick();
        bus.tx_req = 2'b01; bus.tx_len = {8'd0, 8'd3};
        bus.tx_valid = 2'b01; bus.tx_data = {8'h00, 8'h50};
        settle();
        tick(); settle();
        tick(); settle();
        tick(); settle();
        check("t6_first_push", 32'(bus.send_data), 32'h50);
        tick(); rst_n = 1'b0; settle();
        check("t6_grant",     32'(bus.tx_grant),  0);
        check("t6_ready",     32'(bus.tx_ready),  0);
        check("t6_send_flag", 32'(bus.send_flag), 0);
        check("t6_send_data", 32'(bus.send_data), 0);
        check("t6_recv_flag", 32'(bus.recv_flag), 0);
        check("t6_rx_valid",  32'(bus.rx_valid),  0);
        check("t6_rx_last",   32'(bus.rx_last),   0);
        check("t6_rx_data",   32'(bus.rx_data),   0);
        tick(); settle();
        tick();
        rst_n = 1'b1; q_len = q_head;
        bus.tx_req = 2'b11; bus.tx_len = '0;
        settle();
        check("t6_idle_grant", 32'(bus.tx_grant), 0);
        tick(); settle();
        check("t6_rr_grant",  32'(bus.tx_grant),  1);
        check("t6_rr_hdr",    32'(bus.send_data), 0);
        tick(); settle();
        check("t6_len_flag",  32'(bus.send_flag), 1);
        check("t6_len_data",  32'(bus.send_data), 0);
        tick(); bus.tx_req = '0; settle();
        check("t6_end_grant", 32'(bus.tx_grant), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_channel_arbiter.md
# uart_channel_arbiter

Packet-level controller that shares one `uart_trans` byte link between `NUM_CH` on-chip requesters, for example the instruction loader and the debug/console port. On the transmit side it arbitrates round-robin at packet boundaries and frames each packet as header (channel id), length, then payload. On the receive side it parses the same framing from the UART receive FIFO and routes payload bytes to the addressed channel with per-channel backpressure. It connects directly to the `send_*`/`recv_*` side of `uart_trans`.

## Interface
- `NUM_CH`, default 2: number of requesters, legal range 2..8; channel id = index.
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: reset, asynchronous assert, active-low.
- `tx_req`, in, NUM_CH: channel c wants to send a packet; held high until its packet completes.
- `tx_len`, in, 8*NUM_CH: payload length for channel c, bits [8c+7:8c], 0..255; sampled at grant.
- `tx_grant`, out, NUM_CH: one-hot, high for the whole packet of the granted channel.
- `tx_data`, in, 8*NUM_CH: payload byte for channel c.
- `tx_valid`, in, NUM_CH: payload byte valid.
- `tx_ready`, out, NUM_CH: payload byte accepted this cycle when valid and ready are both high.
- `rx_data`, out, 8: payload byte, shared by all channels.
- `rx_valid`, out, NUM_CH: one-hot, byte for channel c.
- `rx_last`, out, 1: current rx byte is the final payload byte.
- `rx_ready`, in, NUM_CH: channel c accepts the byte.
- `rx_drop`, out, 1: one-cycle pulse when a header with id ≥ NUM_CH is popped.
- `send_flag`, out, 1: push `send_data` into the UART TX FIFO.
- `send_data`, out, 8: byte to push.
- `sendable`, in, 1: TX FIFO not full.
- `recv_flag`, out, 1: pop the UART RX FIFO head.
- `recv_data`, in, 8: RX FIFO head, valid while `receivable`.
- `receivable`, in, 1: RX FIFO not empty.

## Operation
- TX FSM states: T_IDLE, T_HDR, T_LEN, T_DATA.
  - T_IDLE: if any `tx_req`, choose the first requester after `last_grant` in round-robin order. Register `gnt`, `cnt` = `tx_len[gnt]`, and `last_grant` = gnt. Next state T_HDR.
  - T_HDR: `send_flag` = `sendable`, `send_data` = gnt zero-extended. On push, next state T_LEN.
  - T_LEN: `send_data` = `cnt`. On push, next state is T_IDLE if `cnt` = 0, otherwise T_DATA.
  - T_DATA: `tx_ready[gnt]` = `sendable`; `send_flag` = `sendable & tx_valid[gnt]`; `send_data` = `tx_data[gnt]`. Each push decrements `cnt`. The push made with `cnt` = 1 returns the FSM to T_IDLE.
  - `tx_grant` = onehot(gnt) in T_HDR, T_LEN and T_DATA; all zeros in T_IDLE.
- RX FSM states: R_HDR, R_LEN, R_DATA, R_DROP.
  - R_HDR: pop when `receivable`. Latch `ch` = `recv_data`, and set `bad` = (`recv_data` ≥ NUM_CH). If `bad`, pulse `rx_drop`. Next state R_LEN.
  - R_LEN: pop and latch `rcnt`. If `rcnt` = 0, next state R_HDR. Otherwise next state is R_DROP if `bad`, else R_DATA.
  - R_DATA: `rx_valid[ch]` = `receivable`; `rx_data` = `recv_data`; `rx_last` = (`rcnt` = 1); `recv_flag` = `receivable & rx_ready[ch]`. Each pop decrements `rcnt`; the pop with `rcnt` = 1 returns the FSM to R_HDR.
  - R_DROP: pop unconditionally while `receivable`, decrementing `rcnt`, then return to R_HDR.
- `send_flag`, `recv_flag`, `tx_ready` and `rx_valid` are combinational from state and inputs. They never assert without `sendable`/`receivable` respectively.
- TX and RX FSMs are fully independent; both directions run concurrently.

## Timing
- Reset (RST low) values:
  - TX state T_IDLE, RX state R_HDR, `last_grant` = NUM_CH-1 (so channel 0 wins first), counters 0.
  - All outputs 0: `tx_grant`, `tx_ready`, `rx_valid`, `rx_last`, `rx_drop`, `send_flag`, `send_data`, `recv_flag`, `rx_data`.
  - `recv_flag` is forced to 0 while RST is low.
- Reset mid-packet abandons the packet on both sides immediately. No byte is pushed or popped in the reset cycle.
- Latency:
  - `tx_req` seen in T_IDLE in cycle n gives `tx_grant` and the header push in cycle n+1, provided `sendable`.
  - The minimum packet cost is len+3 cycles, including one T_IDLE cycle between back-to-back packets.
- Arbitration happens only in T_IDLE. A requester that drops `tx_req` mid-packet is not supported; the packet still runs to `cnt` = 0.
- Requests that arrive simultaneously are resolved by round-robin order. A requester that stays asserted is served at least once every NUM_CH packets.
- `sendable` low stalls the TX FSM in its current state, with no push and no count change. `receivable` low stalls the RX FSM the same way.
- `cnt` and `rcnt` are 8-bit unsigned values. Decrement from 1 to 0 ends the packet; there is no wrap-around.

## Structure
- Package `uart_arb_pkg`: TX and RX state enums (2-bit each), header/length byte width 8, and the maximum payload of 255.
- One sub-module, `rr_arbiter`, parameterised by NUM_CH. Inputs: request vector, `last_grant`. Outputs: one-hot grant and encoded index, purely combinational. The grant is registered by the parent on the T_IDLE exit.

## Test plan
- Single packet: ch1 `tx_req`, len 3, payload 0xA5,0x5A,0xFF with `sendable` held high → pushes 0x01,0x03,0xA5,0x5A,0xFF on consecutive cycles; `tx_grant` = 2'b10 for 5 cycles.
- Contention: ch0 and ch1 both requesting len 1, held for 3 packets → grant order 0,1,0; one T_IDLE cycle between packets.
- TX backpressure: `sendable` toggles every other cycle → no push while `sendable` is low; byte order and count are unchanged.
- RX routing: feed 0x00,0x02,0x11,0x22 with `rx_ready[0]` held low for 4 cycles → `rx_valid` = 01 is held with `rx_data` = 0x11 until ready; `rx_last` is high on 0x22.
- Bad id: feed 0x07,0x02,0xAA,0xBB then 0x01,0x00 → one `rx_drop` pulse; no `rx_valid` for the bad packet; the empty packet for ch1 is consumed cleanly.
- Reset mid-packet: RST low during T_DATA with `cnt` = 2 → all outputs are 0 in the same cycle; after release, a new ch0 request is granted first.
